// File: rtl/router_data_reg.sv
// Datapath register stage of the 1x3 router: latches the header, forwards bytes
// to the FIFO write port (holding one byte across a full condition), and checks parity.
module router_data_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pkt_valid,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  fifo_full,
    input  logic                  detect_addr,
    input  logic                  lfd_state,
    input  logic                  ld_state,
    input  logic                  laf_state,
    input  logic                  full_state,
    input  logic                  rst_int_reg,
    output logic                  parity_done,
    output logic                  low_pkt_valid,
    output logic                  err,
    output logic [DATA_WIDTH-1:0] dout
);

    logic [DATA_WIDTH-1:0] hdr_reg;
    logic [DATA_WIDTH-1:0] hold_reg;
    logic [DATA_WIDTH-1:0] int_parity;
    logic [DATA_WIDTH-1:0] pkt_parity;
    logic [DATA_WIDTH-1:0] dout_reg;
    logic                  parity_done_reg;
    logic                  low_pkt_valid_reg;
    logic                  err_reg;

    logic [DATA_WIDTH-1:0] parity_diff;
    logic                  parity_mismatch;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_diff
            assign parity_diff[gi] = int_parity[gi] ^ pkt_parity[gi];
        end
    endgenerate

    assign parity_mismatch = |parity_diff;

    always_ff @(posedge clk) begin
        if (rst) begin
            hdr_reg           <= '0;
            hold_reg          <= '0;
            int_parity        <= '0;
            pkt_parity        <= '0;
            dout_reg          <= '0;
            parity_done_reg   <= 1'b0;
            low_pkt_valid_reg <= 1'b0;
            err_reg           <= 1'b0;
        end else begin
            // Address 3 is not a valid destination, so it never becomes the header.
            if (detect_addr && pkt_valid && data_in[1:0] != 2'b11)
                hdr_reg <= data_in;

            if (lfd_state)
                dout_reg <= hdr_reg;
            else if (ld_state && !fifo_full)
                dout_reg <= data_in;
            else if (ld_state && fifo_full)
                hold_reg <= data_in;
            else if (laf_state)
                dout_reg <= hold_reg;

            // The parity byte arrives with pkt_valid low, so it is never folded in.
            if (detect_addr)
                int_parity <= '0;
            else if (lfd_state)
                int_parity <= int_parity ^ hdr_reg;
            else if (ld_state && pkt_valid && !full_state)
                int_parity <= int_parity ^ data_in;

            if (detect_addr)
                pkt_parity <= '0;
            else if (ld_state && !pkt_valid)
                pkt_parity <= data_in;

            if (ld_state && !pkt_valid)
                low_pkt_valid_reg <= 1'b1;
            else if (rst_int_reg)
                low_pkt_valid_reg <= 1'b0;

            if (detect_addr)
                parity_done_reg <= 1'b0;
            else if ((ld_state && !fifo_full && !pkt_valid) ||
                     (laf_state && low_pkt_valid_reg && !parity_done_reg))
                parity_done_reg <= 1'b1;

            if (detect_addr)
                err_reg <= 1'b0;
            else if (parity_done_reg)
                err_reg <= parity_mismatch;
        end
    end

    assign dout          = dout_reg;
    assign parity_done   = parity_done_reg;
    assign low_pkt_valid = low_pkt_valid_reg;
    assign err           = err_reg;

endmodule

// File: tb/tb_router_data_reg.sv
// Directed bench for router_data_reg: drives FSM strobes cycle by cycle and
// checks outputs and internal registers against hand-computed values.
module tb_router_data_reg;

    localparam logic [6:0] S_NONE = 7'h00;
    localparam logic [6:0] S_DET  = 7'h01;
    localparam logic [6:0] S_LFD  = 7'h02;
    localparam logic [6:0] S_LD   = 7'h04;
    localparam logic [6:0] S_LAF  = 7'h08;
    localparam logic [6:0] S_FULL = 7'h10;
    localparam logic [6:0] S_RINT = 7'h20;
    localparam logic [6:0] S_RST  = 7'h40;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       pkt_valid = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       fifo_full = 1'b0;
    logic       detect_addr = 1'b0;
    logic       lfd_state = 1'b0;
    logic       ld_state = 1'b0;
    logic       laf_state = 1'b0;
    logic       full_state = 1'b0;
    logic       rst_int_reg = 1'b0;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       err;
    logic [7:0] dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    router_data_reg #(.DATA_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .pkt_valid    (pkt_valid),
        .data_in      (data_in),
        .fifo_full    (fifo_full),
        .detect_addr  (detect_addr),
        .lfd_state    (lfd_state),
        .ld_state     (ld_state),
        .laf_state    (laf_state),
        .full_state   (full_state),
        .rst_int_reg  (rst_int_reg),
        .parity_done  (parity_done),
        .low_pkt_valid(low_pkt_valid),
        .err          (err),
        .dout         (dout)
    );

    task automatic step(input logic [6:0] s, input logic pv, input logic [7:0] d, input logic ff);
        @(negedge clk);
        rst         = s[6];
        rst_int_reg = s[5];
        full_state  = s[4];
        laf_state   = s[3];
        ld_state    = s[2];
        lfd_state   = s[1];
        detect_addr = s[0];
        pkt_valid   = pv;
        data_in     = d;
        fifo_full   = ff;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-16s observed=%h expected=%h", tag, obs, exp);
    endtask

    initial begin
        // Reset state
        step(S_RST, 1'b0, 8'h00, 1'b0);
        chk("rst_dout", dout, 8'h00);
        chk("rst_pdone", {7'd0, parity_done}, 8'h00);
        chk("rst_low", {7'd0, low_pkt_valid}, 8'h00);
        chk("rst_err", {7'd0, err}, 8'h00);

        // 1. Good packet
        step(S_DET, 1'b1, 8'h0D, 1'b0);
        chk("c1_hdr", dut.hdr_reg, 8'h0D);
        step(S_LFD, 1'b1, 8'h11, 1'b0);
        chk("c1_dout_hdr", dout, 8'h0D);
        chk("c1_int_hdr", dut.int_parity, 8'h0D);
        step(S_LD, 1'b1, 8'h11, 1'b0);
        chk("c1_dout_11", dout, 8'h11);
        step(S_LD, 1'b1, 8'h22, 1'b0);
        chk("c1_dout_22", dout, 8'h22);
        step(S_LD, 1'b1, 8'h33, 1'b0);
        chk("c1_dout_33", dout, 8'h33);
        chk("c1_int", dut.int_parity, 8'h0D);
        chk("c1_pdone_pre", {7'd0, parity_done}, 8'h00);
        step(S_LD, 1'b0, 8'h0D, 1'b0);
        chk("c1_dout_par", dout, 8'h0D);
        chk("c1_pdone", {7'd0, parity_done}, 8'h01);
        chk("c1_low", {7'd0, low_pkt_valid}, 8'h01);
        chk("c1_pkt_par", dut.pkt_parity, 8'h0D);
        step(S_NONE, 1'b0, 8'h00, 1'b0);
        chk("c1_err", {7'd0, err}, 8'h00);
        chk("c1_low_hold", {7'd0, low_pkt_valid}, 8'h01);
        step(S_RINT, 1'b0, 8'h00, 1'b0);
        chk("c1_low_clr", {7'd0, low_pkt_valid}, 8'h00);
        chk("c1_err_rint", {7'd0, err}, 8'h00);

        // 2. Bad parity
        step(S_DET, 1'b1, 8'h0D, 1'b0);
        step(S_LFD, 1'b1, 8'h11, 1'b0);
        step(S_LD, 1'b1, 8'h11, 1'b0);
        step(S_LD, 1'b1, 8'h22, 1'b0);
        step(S_LD, 1'b1, 8'h33, 1'b0);
        step(S_LD, 1'b0, 8'h0C, 1'b0);
        chk("c2_pkt_par", dut.pkt_parity, 8'h0C);
        chk("c2_int", dut.int_parity, 8'h0D);
        chk("c2_pdone", {7'd0, parity_done}, 8'h01);
        chk("c2_err_pre", {7'd0, err}, 8'h00);
        step(S_NONE, 1'b0, 8'h00, 1'b0);
        chk("c2_err", {7'd0, err}, 8'h01);
        step(S_RINT, 1'b0, 8'h00, 1'b0);
        chk("c2_err_rint", {7'd0, err}, 8'h01);
        step(S_DET, 1'b1, 8'h0D, 1'b0);
        chk("c2_err_clr", {7'd0, err}, 8'h00);
        chk("c2_pdone_clr", {7'd0, parity_done}, 8'h00);

        // 3. FIFO full mid-payload (the detect above starts this packet)
        step(S_LFD, 1'b1, 8'h11, 1'b0);
        step(S_LD, 1'b1, 8'h11, 1'b0);
        chk("c3_dout_11", dout, 8'h11);
        step(S_LD, 1'b1, 8'h22, 1'b1);
        chk("c3_dout_hold", dout, 8'h11);
        chk("c3_hold", dut.hold_reg, 8'h22);
        step(S_LAF, 1'b1, 8'h33, 1'b0);
        chk("c3_dout_laf", dout, 8'h22);
        chk("c3_pdone_laf", {7'd0, parity_done}, 8'h00);
        step(S_LD, 1'b1, 8'h33, 1'b0);
        chk("c3_dout_33", dout, 8'h33);
        step(S_LD, 1'b0, 8'h0D, 1'b0);
        chk("c3_int", dut.int_parity, 8'h0D);
        chk("c3_pdone", {7'd0, parity_done}, 8'h01);
        step(S_NONE, 1'b0, 8'h00, 1'b0);
        chk("c3_err", {7'd0, err}, 8'h00);
        step(S_RINT, 1'b0, 8'h00, 1'b0);

        // 4. Full on the parity byte
        step(S_DET, 1'b1, 8'h0D, 1'b0);
        step(S_LFD, 1'b1, 8'h11, 1'b0);
        step(S_LD, 1'b1, 8'h11, 1'b0);
        step(S_LD, 1'b1, 8'h22, 1'b0);
        step(S_LD, 1'b1, 8'h33, 1'b0);
        step(S_LD, 1'b0, 8'h0D, 1'b1);
        chk("c4_low", {7'd0, low_pkt_valid}, 8'h01);
        chk("c4_pdone_pre", {7'd0, parity_done}, 8'h00);
        chk("c4_dout_hold", dout, 8'h33);
        chk("c4_pkt_par", dut.pkt_parity, 8'h0D);
        step(S_FULL, 1'b0, 8'h00, 1'b1);
        chk("c4_pdone_full", {7'd0, parity_done}, 8'h00);
        step(S_LAF, 1'b0, 8'h00, 1'b0);
        chk("c4_dout_laf", dout, 8'h0D);
        chk("c4_pdone", {7'd0, parity_done}, 8'h01);
        step(S_NONE, 1'b0, 8'h00, 1'b0);
        chk("c4_err", {7'd0, err}, 8'h00);
        step(S_RINT, 1'b0, 8'h00, 1'b0);
        chk("c4_low_clr", {7'd0, low_pkt_valid}, 8'h00);

        // 5. Illegal address
        step(S_DET, 1'b1, 8'h0E, 1'b0);
        chk("c5_hdr_legal", dut.hdr_reg, 8'h0E);
        step(S_DET, 1'b1, 8'h0F, 1'b0);
        chk("c5_hdr_illegal", dut.hdr_reg, 8'h0E);

        // 6. Reset mid-packet
        step(S_DET, 1'b1, 8'h0D, 1'b0);
        step(S_LFD, 1'b1, 8'h11, 1'b0);
        step(S_LD, 1'b1, 8'h11, 1'b0);
        step(S_LD, 1'b1, 8'h22, 1'b0);
        chk("c6_int_pre", dut.int_parity, 8'h3E);
        step(S_RST | S_LD, 1'b0, 8'h33, 1'b1);
        chk("c6_dout", dout, 8'h00);
        chk("c6_pdone", {7'd0, parity_done}, 8'h00);
        chk("c6_low", {7'd0, low_pkt_valid}, 8'h00);
        chk("c6_err", {7'd0, err}, 8'h00);
        chk("c6_int", dut.int_parity, 8'h00);
        chk("c6_hdr", dut.hdr_reg, 8'h00);
        chk("c6_hold", dut.hold_reg, 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/router_data_reg.md
Name: router_data_reg

Overview:
- Datapath register stage of the 1x3 router, directly downstream of the router FSM controller.
- Consumes the FSM state strobes (detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg).
- Latches the header and forwards header/payload/parity bytes to the FIFO write port, holding a byte while the FIFO is full.
- Computes running packet parity and returns parity_done, low_pkt_valid and err to the FSM and top level.

Parameters:
- DATA_WIDTH, 8, byte width of data_in/dout. Header layout is fixed: [1:0] = destination address, [7:2] = payload length.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- pkt_valid  input  1  source asserts while header/payload bytes are on data_in; deasserts on the parity byte.
- data_in  input  DATA_WIDTH  packet byte from source.
- fifo_full  input  1  selected destination FIFO full.
- detect_addr  input  1  FSM in DECODE_ADDRESS.
- lfd_state  input  1  FSM in LOAD_FIRST_DATA.
- ld_state  input  1  FSM in LOAD_DATA.
- laf_state  input  1  FSM in LOAD_AFTER_FULL.
- full_state  input  1  FSM in FIFO_FULL_STATE.
- rst_int_reg  input  1  FSM in CHECK_PARITY_ERROR.
- parity_done  output  1  parity byte has been accepted.
- low_pkt_valid  output  1  pkt_valid fell while loading (end of packet seen).
- err  output  1  computed parity differs from received parity byte.
- dout  output  DATA_WIDTH  byte to FIFO write data.

Behaviour:
- Internal registers: hdr_reg, hold_reg (full-hold byte), int_parity, pkt_parity; all DATA_WIDTH, all reset to 0.
- Reset: rst=1 at a posedge sets dout, hdr_reg, hold_reg, int_parity, pkt_parity, parity_done, low_pkt_valid and err to 0. Reset takes priority over every other update, including mid-packet.
- Header capture: if detect_addr && pkt_valid && data_in[1:0] != 2'b11, then hdr_reg <= data_in. Address 3 is never captured.
- dout update priority (first match wins; otherwise dout holds):
  1. lfd_state: dout <= hdr_reg.
  2. ld_state && !fifo_full: dout <= data_in.
  3. ld_state && fifo_full: hold_reg <= data_in; dout holds.
  4. laf_state: dout <= hold_reg.
- int_parity:
  - detect_addr: cleared to 0.
  - lfd_state: int_parity ^= hdr_reg.
  - ld_state && pkt_valid && !full_state: int_parity ^= data_in.
  - Otherwise holds. The parity byte itself is never folded into int_parity.
- pkt_parity: if ld_state && !pkt_valid, then pkt_parity <= data_in. Cleared on detect_addr.
- low_pkt_valid: set when ld_state && !pkt_valid; cleared when rst_int_reg; otherwise holds. Set has priority over clear if both occur in the same cycle.
- parity_done:
  - Cleared on detect_addr.
  - Set when ld_state && !fifo_full && !pkt_valid.
  - Also set when laf_state && low_pkt_valid && !parity_done.
  - Otherwise holds. It is sticky until the next detect_addr.
- err:
  - Cleared on detect_addr.
  - When parity_done==1, err <= (int_parity != pkt_parity); otherwise holds.
  - Latency: valid one clock after parity_done rises, and remains valid through CHECK_PARITY_ERROR.
- Full during parity byte: with ld_state && fifo_full && !pkt_valid, the parity byte goes to hold_reg and pkt_parity, and low_pkt_valid sets. parity_done sets later via the laf_state path. The parity byte is delivered on dout in laf_state.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. Good packet:
   - Stimulus: header 0x0D (addr 1, len 3), payload 0x11/0x22/0x33, parity 0x0D, FIFO never full, FSM strobes sequenced normally.
   - Required: dout sequence 0x0D, 0x11, 0x22, 0x33, 0x0D; parity_done=1 one clock after the parity byte; err=0; low_pkt_valid=1 until rst_int_reg.
2. Bad parity:
   - Stimulus: same packet with parity byte 0x0C.
   - Required: pkt_parity=0x0C, int_parity=0x0D, err=1 one clock after parity_done rises.
   - Then detect_addr -> err=0 and parity_done=0.
3. FIFO full mid-payload:
   - Stimulus: fifo_full=1 during ld_state with data_in=0x22.
   - Required: dout holds 0x11 and hold_reg=0x22. Next laf_state -> dout=0x22. Final int_parity is unchanged versus case 1 and err=0.
4. Full on parity byte:
   - Stimulus: fifo_full=1 while ld_state && !pkt_valid with data_in=0x0D.
   - Required: low_pkt_valid=1 and parity_done=0. Then laf_state -> dout=0x0D and parity_done=1.
5. Illegal address:
   - Stimulus: detect_addr && pkt_valid with data_in=0x0F (addr 3).
   - Required: hdr_reg unchanged from its previous value.
6. Reset mid-packet:
   - Stimulus: rst=1 for one posedge during ld_state after two payload bytes.
   - Required: dout=0, parity_done=0, low_pkt_valid=0, err=0 and int_parity=0 on the next cycle, regardless of the strobes.
